prog_run_ctrl: RTL and testbench
================================

// Module: prog_run_ctrl
// PURPOSE
//  Replaces hand-driven bench sequencing around the multi-cycle 16-bit RISC datapath.
//  Phase 1: loads a program/data image into datapath memory via Ext_Mem_Addr/Ext_MemW_Data (valid/ready stream).
//  Phase 2: resets PC, enables the control unit, captures OutR results into an output FIFO.
//  Phase 3: stops on HLT or watchdog timeout.
// PARAMETERS
//  DATA_W      16    memory word / OutR width
//  ADDR_W      16    memory address width
//  FIFO_DEPTH  8     OutR capture FIFO entries (power of 2, >=2)
//  MAX_CYCLES  4096  RUN-state watchdog limit, in clk cycles
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous reset, active-high
//  start          in   1       begin load; sampled only in IDLE/DONE
//  ld_valid       in   1       load word valid
//  ld_ready       out  1       load word accepted when ld_valid&ld_ready
//  ld_addr        in   ADDR_W  target memory address
//  ld_data        in   DATA_W  word to write
//  ld_last        in   1       marks final load word
//  Mem_Addr_Sel   out  1       1: memory addressed by Ext_Mem_Addr
//  MemW_Data_Sel  out  1       1: memory data from Ext_MemW_Data
//  MemW_en        out  1       loader write strobe; top level ORs with control-unit write
//  Ext_Mem_Addr   out  ADDR_W  = ld_addr
//  Ext_MemW_Data  out  DATA_W  = ld_data
//  pc_reset       out  1       one-cycle PC_Sel=11 and PC_CE request
//  cpu_run        out  1       control-unit enable
//  halt_in        in   1       HLT decoded by control unit
//  outr_strobe    in   1       Out_R_CE pulse from control unit
//  outr_data      in   DATA_W  value being loaded into Out_R
//  out_valid      out  1       FIFO not empty
//  out_ready      in   1       consumer pop
//  out_data       out  DATA_W  FIFO head
//  done           out  1       high in DONE
//  timeout        out  1       sticky; watchdog fired
//  overflow       out  1       sticky; strobe arrived while FIFO full
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, FIFO empty, counters 0, timeout=overflow=0.
//   - Mem_Addr_Sel=1, MemW_Data_Sel=1, all other outputs 0.
//  State machine:
//   IDLE:   start -> LOAD; clear timeout, overflow, cycle count.
//   LOAD:   ld_ready=1; Mem_Addr_Sel=MemW_Data_Sel=1; MemW_en = ld_valid (combinational).
//           Memory writes on the same edge as the accept.
//           Accept with ld_last=1 -> PC_RST. No timeout while loading.
//   PC_RST: exactly one cycle; pc_reset=1; Mem_Addr_Sel=MemW_Data_Sel=0 -> RUN.
//   RUN:    cpu_run=1; selects stay 0; cycle count increments each cycle.
//           halt_in -> DRAIN.
//           Count == MAX_CYCLES-1 without halt -> timeout=1, DRAIN.
//           halt_in and watchdog in the same cycle: halt wins, timeout stays 0.
//   DRAIN:  cpu_run=0; strobes ignored; FIFO empty -> DONE. Zero-cycle-empty case still spends one cycle here.
//   DONE:   done=1; Mem_Addr_Sel=MemW_Data_Sel=1; start -> LOAD (flags cleared, count reset).
//  Start handling: start ignored in LOAD/PC_RST/RUN/DRAIN.
//  Capture FIFO:
//   - Push only in RUN on outr_strobe; capture includes the halt_in cycle.
//   - Pop on out_valid&out_ready in any state.
//   - Push+pop same cycle when full: both happen, no overflow.
//   - Push while full without pop: data dropped, overflow=1 (sticky until next start/rst).
//   - Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
//   - out_data is registered FIFO head, valid whenever out_valid=1.
//  Reset mid-operation: rst in any state returns to IDLE next edge.
//   - An in-flight load write is not issued on the reset edge (MemW_en gated by !rst).
// TESTING
//  T1 load: 3 words (00h:1025h, 01h:E000h, 40h:0047h), ld_valid low one cycle between words 2 and 3.
//      -> 3 MemW_en pulses with matching Ext addr/data; ld_last -> PC_RST 1 cycle, then RUN.
//  T2 capture: in RUN, strobes 0025h, 6325h, 0047h; out_ready=1.
//      -> out_data 0025h, 6325h, 0047h in order; halt_in -> DRAIN -> DONE, done=1.
//  T3 overflow: out_ready=0, FIFO_DEPTH+1 strobes.
//      -> first 8 kept, overflow=1. Full FIFO + strobe + pop same cycle -> no overflow.
//  T4 simultaneous: outr_strobe=1 with halt_in=1 (data 1234h).
//      -> 1234h captured; cpu_run=0 next cycle.
//  T5 watchdog: MAX_CYCLES=16, no halt.
//      -> after 16 RUN cycles timeout=1, DRAIN, DONE. Halt on cycle 16 -> timeout=0.
//  T6 reset mid-LOAD after 2 accepted words.
//      -> all outputs at reset values next edge. New start reloads; flags are 0.

Source files
------------

// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: sequences a program run on the multi-cycle 16-bit RISC datapath.
// Streams a load image into datapath memory, pulses a PC reset, lets the control
// unit run while capturing OutR values into a small FIFO, and stops on HLT or
// when the RUN-state watchdog expires.
module prog_run_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              Mem_Addr_Sel,
    output logic              MemW_Data_Sel,
    output logic              MemW_en,
    output logic [ADDR_W-1:0] Ext_Mem_Addr,
    output logic [DATA_W-1:0] Ext_MemW_Data,
    output logic              pc_reset,
    output logic              cpu_run,
    input  logic              halt_in,
    input  logic              outr_strobe,
    input  logic [DATA_W-1:0] outr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PC_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cycle_cnt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;

    logic fifo_empty;
    logic fifo_full;
    logic push_req;
    logic push;
    logic pop;
    logic start_ok;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && out_ready;
    assign push_req   = (state == S_RUN) && outr_strobe;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_mem[rd_ptr];

    // The loader write strobe is combinational so memory writes on the accept
    // edge; it is suppressed on a reset edge so a half-finished load never
    // lands in memory.
    assign MemW_en       = ld_ready && ld_valid && !rst;
    assign Ext_Mem_Addr  = ld_addr;
    assign Ext_MemW_Data = ld_data;

    // Sequencer: state, registered control outputs and the RUN watchdog.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ld_ready      <= 1'b0;
            Mem_Addr_Sel  <= 1'b1;
            MemW_Data_Sel <= 1'b1;
            pc_reset      <= 1'b0;
            cpu_run       <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            cycle_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        ld_ready  <= 1'b1;
                        done      <= 1'b0;
                        timeout   <= 1'b0;
                        cycle_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid && ld_ready && ld_last) begin
                        state         <= S_PC_RST;
                        ld_ready      <= 1'b0;
                        pc_reset      <= 1'b1;
                        Mem_Addr_Sel  <= 1'b0;
                        MemW_Data_Sel <= 1'b0;
                    end
                end
                S_PC_RST: begin
                    state    <= S_RUN;
                    pc_reset <= 1'b0;
                    cpu_run  <= 1'b1;
                end
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    // Halt takes priority so a program finishing on the last
                    // allowed cycle is not reported as a timeout.
                    if (halt_in) begin
                        state   <= S_DRAIN;
                        cpu_run <= 1'b0;
                    end else if (cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
                        state   <= S_DRAIN;
                        cpu_run <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state         <= S_DONE;
                        done          <= 1'b1;
                        Mem_Addr_Sel  <= 1'b1;
                        MemW_Data_Sel <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (start_ok)
                overflow <= 1'b0;
            else if (push_req && !push)
                overflow <= 1'b1;
        end
    end

    // Capture FIFO storage.
    // NOTE: the storage array has no reset; occupancy and pointers define which
    // entries are meaningful, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= outr_data;
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb_prog_run_ctrl: directed and randomized checks of the program run
// sequencer against a queue-based model of the capture FIFO and flags.
module tb_prog_run_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int MAXC  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          Mem_Addr_Sel;
    logic          MemW_Data_Sel;
    logic          MemW_en;
    logic [AW-1:0] Ext_Mem_Addr;
    logic [DW-1:0] Ext_MemW_Data;
    logic          pc_reset;
    logic          cpu_run;
    logic          halt_in;
    logic          outr_strobe;
    logic [DW-1:0] outr_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          done;
    logic          timeout;
    logic          overflow;

    prog_run_ctrl #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .FIFO_DEPTH(DEPTH),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .Mem_Addr_Sel (Mem_Addr_Sel),
        .MemW_Data_Sel(MemW_Data_Sel),
        .MemW_en      (MemW_en),
        .Ext_Mem_Addr (Ext_Mem_Addr),
        .Ext_MemW_Data(Ext_MemW_Data),
        .pc_reset     (pc_reset),
        .cpu_run      (cpu_run),
        .halt_in      (halt_in),
        .outr_strobe  (outr_strobe),
        .outr_data    (outr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .done         (done),
        .timeout      (timeout),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: FIFO contents in arrival order and the two sticky flags.
    logic [DW-1:0] mq [$];
    bit            m_ovf;
    bit            m_to;

    // Load image for the next run.
    logic [AW-1:0] wa [$];
    logic [DW-1:0] wd [$];
    bit            wg [$];

    // {ld_ready, Mem_Addr_Sel, MemW_Data_Sel, MemW_en, pc_reset, cpu_run,
    //  out_valid, done, timeout, overflow}
    localparam logic [9:0] ST_RESET = 10'b0110000000;
    localparam logic [9:0] ST_LOAD  = 10'b1110000000;
    localparam logic [9:0] ST_PCRST = 10'b0000100000;
    localparam logic [9:0] ST_RUN   = 10'b0000010000;

    function automatic logic [9:0] status();
        return {ld_ready, Mem_Addr_Sel, MemW_Data_Sel, MemW_en, pc_reset,
                cpu_run, out_valid, done, timeout, overflow};
    endfunction

    task automatic check(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE/DONE, stream the load image, pass PC_RST, end in RUN cycle 0.
    task automatic begin_run(input string tag);
        int pulses;
        pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check(status() === ST_LOAD,
              $sformatf("%s load_entry: got %b want %b", tag, status(), ST_LOAD));
        for (int i = 0; i < wa.size(); i++) begin
            if (wg[i]) begin
                ld_valid = 1'b0;
                #1;
                check(MemW_en === 1'b0,
                      $sformatf("%s gap_write: got %b want 0", tag, MemW_en));
                tick();
            end
            ld_valid = 1'b1;
            ld_addr  = wa[i];
            ld_data  = wd[i];
            ld_last  = (i == wa.size() - 1);
            #1;
            if (MemW_en === 1'b1) pulses++;
            check(Ext_Mem_Addr === wa[i] && Ext_MemW_Data === wd[i] && ld_ready === 1'b1,
                  $sformatf("%s word%0d: got %h:%h rdy=%b want %h:%h rdy=1", tag, i,
                            Ext_Mem_Addr, Ext_MemW_Data, ld_ready, wa[i], wd[i]));
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        check(pulses == wa.size(),
              $sformatf("%s write_pulses: got %0d want %0d", tag, pulses, wa.size()));
        check(status() === ST_PCRST,
              $sformatf("%s pc_rst: got %b want %b", tag, status(), ST_PCRST));
        tick();
        check(status() === ST_RUN,
              $sformatf("%s run_entry: got %b want %b", tag, status(), ST_RUN));
        m_ovf = 1'b0;
        m_to  = 1'b0;
    endtask

    // One clock of FIFO traffic, checked against the model before the edge.
    task automatic fifo_cycle(input bit in_run, input bit strobe, input logic [DW-1:0] data,
                              input bit ready, input bit halt);
        int sz;
        bit pop;
        outr_strobe = strobe;
        outr_data   = data;
        out_ready   = ready;
        halt_in     = halt;
        #1;
        check(out_valid === (mq.size() != 0),
              $sformatf("out_valid: got %b want %b", out_valid, mq.size() != 0));
        if (mq.size() != 0)
            check(out_data === mq[0],
                  $sformatf("out_data: got %h want %h", out_data, mq[0]));
        check(overflow === m_ovf,
              $sformatf("overflow_flag: got %b want %b", overflow, m_ovf));
        sz  = mq.size();
        pop = (sz != 0) && ready;
        if (pop) void'(mq.pop_front());
        if (in_run && strobe) begin
            if (sz < DEPTH || pop) mq.push_back(data);
            else m_ovf = 1'b1;
        end
        tick();
        outr_strobe = 1'b0;
        halt_in     = 1'b0;
        out_ready   = 1'b0;
    endtask

    task automatic drain_to_done(input string tag);
        int n;
        logic [9:0] want;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            fifo_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check(done === 1'b1,
              $sformatf("%s done_wait: got %b want 1 within 40 cycles", tag, done));
        want = {7'b0110000, 1'b1, m_to, m_ovf};
        check(status() === want,
              $sformatf("%s done_state: got %b want %b", tag, status(), want));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check(status() === ST_RESET,
              $sformatf("reset_state: got %b want %b", status(), ST_RESET));
        rst = 1'b0;
    endtask

    task automatic test_load();
        wa = '{16'h0000, 16'h0001, 16'h0040};
        wd = '{16'h1025, 16'hE000, 16'h0047};
        wg = '{1'b0, 1'b0, 1'b1};
        begin_run("load");
    endtask

    task automatic test_capture();
        fifo_cycle(1'b1, 1'b1, 16'h0025, 1'b1, 1'b0);
        fifo_cycle(1'b1, 1'b1, 16'h6325, 1'b1, 1'b0);
        fifo_cycle(1'b1, 1'b1, 16'h0047, 1'b1, 1'b0);
        start = 1'b1;
        fifo_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        start = 1'b0;
        check(cpu_run === 1'b1 && ld_ready === 1'b0,
              $sformatf("start_in_run: got run=%b rdy=%b want run=1 rdy=0", cpu_run, ld_ready));
        fifo_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check(cpu_run === 1'b0,
              $sformatf("halt_stop: got cpu_run=%b want 0", cpu_run));
        drain_to_done("capture");
    endtask

    task automatic test_overflow();
        wa = '{16'h0010};
        wd = '{16'h7000};
        wg = '{1'b0};
        begin_run("ovf");
        for (int i = 0; i <= DEPTH; i++)
            fifo_cycle(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        check(overflow === 1'b1,
              $sformatf("overflow_set: got %b want 1", overflow));
        fifo_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        drain_to_done("ovf");

        begin_run("full_pop");
        for (int i = 0; i < DEPTH; i++)
            fifo_cycle(1'b1, 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        fifo_cycle(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
        check(overflow === 1'b0,
              $sformatf("full_push_pop: got overflow=%b want 0", overflow));
        fifo_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        drain_to_done("full_pop");
    endtask

    task automatic test_halt_strobe();
        begin_run("halt_strobe");
        fifo_cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        check(cpu_run === 1'b0 && out_valid === 1'b1 && out_data === 16'h1234,
              $sformatf("halt_capture: got run=%b v=%b d=%h want run=0 v=1 d=1234",
                        cpu_run, out_valid, out_data));
        drain_to_done("halt_strobe");
    endtask

    task automatic test_watchdog();
        begin_run("wdog");
        for (int i = 0; i < MAXC - 1; i++) fifo_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check(cpu_run === 1'b1 && timeout === 1'b0,
              $sformatf("wdog_early: got run=%b to=%b want run=1 to=0", cpu_run, timeout));
        fifo_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check(cpu_run === 1'b0 && timeout === 1'b1,
              $sformatf("wdog_fire: got run=%b to=%b want run=0 to=1", cpu_run, timeout));
        m_to = 1'b1;
        drain_to_done("wdog");

        begin_run("wdog_halt");
        for (int i = 0; i < MAXC - 1; i++) fifo_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        fifo_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check(cpu_run === 1'b0 && timeout === 1'b0,
              $sformatf("wdog_halt_wins: got run=%b to=%b want run=0 to=0", cpu_run, timeout));
        drain_to_done("wdog_halt");
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 16'h0300 + 16'(i);
            ld_data  = 16'($urandom);
            ld_last  = 1'b0;
            tick();
        end
        ld_addr = 16'h0302;
        rst     = 1'b1;
        #1;
        check(MemW_en === 1'b0,
              $sformatf("reset_gates_write: got %b want 0", MemW_en));
        tick();
        rst      = 1'b0;
        ld_valid = 1'b0;
        #1;
        check(status() === ST_RESET,
              $sformatf("reset_mid_load: got %b want %b", status(), ST_RESET));
        wa = '{16'h0000, 16'h0001};
        wd = '{16'hAAAA, 16'h5555};
        wg = '{1'b0, 1'b1};
        begin_run("reload");
        fifo_cycle(1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b1);
        drain_to_done("reload");
    endtask

    task automatic test_random();
        for (int e = 0; e < 6; e++) begin
            int n;
            int k;
            n = $urandom_range(1, 4);
            wa.delete();
            wd.delete();
            wg.delete();
            for (int i = 0; i < n; i++) begin
                wa.push_back(16'($urandom));
                wd.push_back(16'($urandom));
                wg.push_back(($urandom % 3) == 0);
            end
            begin_run("rand");
            k = $urandom_range(1, 12);
            for (int j = 0; j < k; j++)
                fifo_cycle(1'b1, 1'($urandom % 2), 16'($urandom), 1'($urandom % 2), 1'b0);
            fifo_cycle(1'b1, 1'($urandom % 2), 16'($urandom), 1'($urandom % 2), 1'b1);
            drain_to_done("rand");
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        ld_last     = 1'b0;
        halt_in     = 1'b0;
        outr_strobe = 1'b0;
        outr_data   = '0;
        out_ready   = 1'b0;
        m_ovf       = 1'b0;
        m_to        = 1'b0;
        test_reset();
        test_load();
        test_capture();
        test_overflow();
        test_halt_strobe();
        test_watchdog();
        test_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
